// File: rtl/arm_fetch_pkg.sv
// Shared types for the ARM instruction fetch path: sequencer states, the PC step,
// and the queue entry that pairs a fetched word with its PC.
package arm_fetch_pkg;

  localparam int PKG_ADDR_W = 32;
  localparam logic [PKG_ADDR_W-1:0] PC_INC = 32'd4;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_REDIRECT,
    ST_HALTED,
    ST_FAULT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]           instr;
    logic [PKG_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched {instr, pc} entries between fetch and decode.
// Flush has priority over push and pop.
module fetch_queue
  import arm_fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [31:0]           i_instr,
  input  logic [PKG_ADDR_W-1:0] i_pc,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [31:0]           o_head_instr,
  output logic [PKG_ADDR_W-1:0] o_head_pc
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  fetch_entry_t     r_mem [QDEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(QDEPTH));
  assign w_pop_ok  = i_pop && !o_empty;
  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  assign o_head_instr = r_mem[r_rd_ptr].instr;
  assign o_head_pc    = r_mem[r_rd_ptr].pc;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; the head is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) begin
      r_mem[r_wr_ptr].instr <= i_instr;
      r_mem[r_wr_ptr].pc    <= i_pc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches from a combinational instruction
// memory into a small queue, and handles branch redirects, halt and bad-target faults.
module fetch_sequencer
  import arm_fetch_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 128,
  parameter int          QDEPTH    = 2
) (
  input  logic              clk,
  input  logic              nreset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              fault
);

  fetch_state_e          r_state;
  fetch_state_e          w_state_nxt;
  logic [ADDR_W-1:0]     r_fetch_pc;
  logic [ADDR_W-1:0]     w_pc_nxt;
  logic [ADDR_W-1:0]     w_seq_pc;
  logic                  r_fault;
  logic                  w_fire;
  logic                  w_flush;
  logic                  w_set_fault;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_tgt_legal;
  logic [31:0]           w_head_instr;
  logic [PKG_ADDR_W-1:0] w_head_pc;

  assign w_tgt_legal = (br_target[1:0] == 2'b00) && (br_target < ADDR_W'(MEM_BYTES));
  // Sequential fetch wraps from the last word back to address zero.
  assign w_seq_pc    = (r_fetch_pc == ADDR_W'(MEM_BYTES - 4)) ? '0
                                                               : r_fetch_pc + ADDR_W'(PC_INC);
  assign w_pop       = !w_empty && instr_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_fetch_pc;
    w_fire      = 1'b0;
    w_flush     = 1'b0;
    w_set_fault = 1'b0;
    case (r_state)
      ST_BOOT:  w_state_nxt = ST_FETCH;
      ST_FAULT: w_state_nxt = ST_FAULT;
      default: begin
        if (br_valid) begin
          w_flush = 1'b1;
          if (w_tgt_legal) begin
            w_pc_nxt    = br_target;
            w_state_nxt = (r_state == ST_HALTED) ? ST_HALTED : ST_REDIRECT;
          end else begin
            w_set_fault = 1'b1;
            w_state_nxt = ST_FAULT;
          end
        end else begin
          case (r_state)
            ST_FETCH: begin
              if (halt) begin
                w_state_nxt = ST_HALTED;
              end else if (!w_full || w_pop) begin
                w_fire   = 1'b1;
                w_pc_nxt = w_seq_pc;
              end
            end
            ST_REDIRECT: w_state_nxt = halt ? ST_HALTED : ST_FETCH;
            ST_HALTED:   if (!halt) w_state_nxt = ST_FETCH;
            default:     w_state_nxt = r_state;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= ST_BOOT;
      r_fetch_pc <= ADDR_W'(RESET_PC);
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_pc_nxt;
      if (w_set_fault) r_fault <= 1'b1;
    end
  end

  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk         (clk),
    .nreset      (nreset),
    .i_push      (w_fire),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .i_instr     (imem_data),
    .i_pc        (PKG_ADDR_W'(r_fetch_pc)),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_instr(w_head_instr),
    .o_head_pc   (w_head_pc)
  );

  // Head fields read as zero whenever nothing valid is presented.
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = !w_empty;
  assign instr       = w_empty ? '0 : w_head_instr;
  assign instr_pc    = w_empty ? '0 : ADDR_W'(w_head_pc);
  assign fault       = r_fault;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the instruction memory for the ARM datapath.
- Owns the program counter and drives the instruction memory word address; the memory returns the word combinationally.
- Buffers fetched words with their PCs in a 2-entry queue and presents them to decode over a valid/ready handshake.
- Handles branch redirects, halt, and illegal-target faults.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- MEM_BYTES, 128, instruction memory size in bytes; legal PCs are 0..MEM_BYTES-4, word aligned.
- QDEPTH, 2, instruction queue entries (power of two, >= 2).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- nreset, input, 1, asynchronous active-low reset.
- imem_addr, output, ADDR_W, fetch address to instruction memory; equals internal fetch_pc.
- imem_data, input, 32, instruction word returned combinationally for imem_addr.
- br_valid, input, 1, redirect request from execute; single-cycle pulse.
- br_target, input, ADDR_W, redirect address, sampled when br_valid=1.
- halt, input, 1, level; suppresses new fetches while high.
- instr_valid, output, 1, queue head valid.
- instr, output, 32, queue head instruction word.
- instr_pc, output, ADDR_W, PC of queue head.
- instr_ready, input, 1, decode accepts head when instr_valid & instr_ready.
- fault, output, 1, sticky illegal-branch-target flag.

Behaviour:
- Reset (nreset=0, async):
  - fetch_pc=RESET_PC; queue empty; instr_valid=0; instr=0; instr_pc=0; fault=0.
  - State=BOOT. BOOT lasts exactly one clock after reset deasserts, then goes to FETCH. No fetch in BOOT.
- States:
  - BOOT: next state FETCH.
  - FETCH: normal operation; see the FETCH rules below.
  - REDIRECT: one bubble cycle, no fetch; next state FETCH, or HALTED if halt=1.
  - HALTED: no fetch; queue drains normally; halt=0 returns to FETCH.
  - FAULT: absorbing; only nreset exits.
- FETCH rules:
  - Fetch fires when halt=0 and br_valid=0 and (count<QDEPTH, or a pop occurs this cycle).
  - On fire: push {imem_data, fetch_pc}; fetch_pc += 4.
  - Steady state: one instruction per cycle; zero-cycle latency from address to queue write, first instr_valid one cycle after the fetch.
- Wrap-around: a sequential increment from MEM_BYTES-4 sets fetch_pc to 0 (no fault).
- Queue:
  - Circular buffer with rd/wr pointers and a count.
  - Push and pop in the same cycle with count=QDEPTH is legal; count is unchanged.
  - Pop with count=0 cannot occur because instr_valid=0.
  - instr and instr_pc hold the head entry and are stable while instr_valid=1 and instr_ready=0.
- Branch (br_valid=1, any state except FAULT/BOOT):
  - Target legal (aligned, < MEM_BYTES):
    - Flush the queue (count=0, instr_valid=0 next cycle) and set fetch_pc=br_target.
    - A pop in the same cycle is discarded; the branch wins.
    - No fetch that cycle; next state REDIRECT.
    - A branch in HALTED updates fetch_pc and flushes, but stays HALTED.
  - Target illegal (br_target[1:0]!=0 or br_target>=MEM_BYTES):
    - fault=1, flush, state FAULT; fetch_pc keeps its old value.
- halt=1 in FETCH: no fetch from that cycle on; state HALTED next cycle; queued entries remain and can still be popped.
- br_valid during REDIRECT: handled as a new branch; the latest target wins.
- imem_addr is driven only from the fetch_pc register (no combinational path from br_target).

Decomposition:
- Shared package (arm_fetch_pkg):
  - fetch state enum {BOOT, FETCH, REDIRECT, HALTED, FAULT};
  - PC increment constant 4;
  - the queue entry struct {instr[31:0], pc[ADDR_W-1:0]}.
- One sub-module: fetch_queue.
  - Parameterized QDEPTH FIFO with push, pop, flush, full, empty, head outputs.
  - Flush has priority over push and pop.
- The sequencer holds the FSM, PC, legality check, and handshake glue.

Test Plan:
- Reset, then instr_ready=1, memory preloaded: instr_pc sequence 0,4,8,... one per cycle; first instr_valid 2 cycles after nreset rises; instr matches memory word at each PC.
- instr_ready=0 for 5 cycles: queue fills to 2; fetch_pc stops at 8; instr_pc holds 0. Releasing ready yields 0,4,8 with no gap or duplicate.
- br_valid with br_target=32 while the queue holds PCs 4 and 8, pop asserted the same cycle: the popped entry is dropped, instr_valid=0 for 2 cycles, then instr_pc=32,36.
- MEM_BYTES=128, run sequentially from 120: instr_pc 120,124,0,4; fault stays 0.
- br_target=0x22 (unaligned), then separately br_target=128: fault=1, instr_valid=0, imem_addr frozen; only nreset clears fault to 0.
- halt=1 with queue full: the two entries drain, no new PCs appear. halt=0 resumes at the next sequential PC. A branch to 64 during halt resumes at 64 after release.
